// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants: data-bit encodings, limits,
// sequencer state encoding and the frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_e;

  typedef enum logic [1:0] {
    IDLE,
    HALF,
    BITS
  } rx_state_e;

  localparam int unsigned MIN_BAUD_K     = 4;
  localparam int unsigned MAX_FRAME_BITS = 12;

  // Total bits in a frame: start + data + optional parity + one or two stops.
  function automatic logic [3:0] frame_bits(input data_bits_e db, input logic pen,
                                            input logic stop2);
    logic [3:0] d;
    case (db)
      DB5:     d = 4'd5;
      DB6:     d = 4'd6;
      DB7:     d = 4'd7;
      default: d = 4'd8;
    endcase
    return 4'd1 + d + {3'b000, pen} + (stop2 ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/uart_rx_sequencer_bit_timer.sv
// Bit-period timer: free-running count with clear/enable and compares against
// the half-bit and full-bit terminal counts of the latched period.
module bit_timer #(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [BAUD_W-1:0] k,
  output logic              half_hit,
  output logic              full_hit
);

  logic [BAUD_W-1:0] timer_q;
  logic [BAUD_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (en) begin
      timer_d = timer_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign half_hit = (timer_q == ((k >> 1) - BAUD_W'(1)));
  assign full_hit = (timer_q == (k - BAUD_W'(1)));

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART RX frame sequencer: times half a bit to the start-bit centre, then whole
// bits, strobing sample/bit_idx at each centre and done on the last bit.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = 19,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic [1:0]        data_bits,
  input  logic              pen,
  input  logic              stop2,
  output logic              busy,
  output logic              sample,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              done
);

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] k_q, k_d;
  data_bits_e        db_q, db_d;
  logic              pen_q, pen_d;
  logic              stop2_q, stop2_d;
  logic              sample_q, sample_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

  logic              timer_clr;
  logic              timer_en;
  logic              half_hit;
  logic              full_hit;
  logic [IDX_W-1:0]  last_idx;

  assign last_idx = IDX_W'(frame_bits(db_q, pen_q, stop2_q) - 4'd1);
  assign busy     = (state_q != IDLE);

  bit_timer #(
    .BAUD_W(BAUD_W)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .k       (k_q),
    .half_hit(half_hit),
    .full_hit(full_hit)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    db_d      = db_q;
    pen_d     = pen_q;
    stop2_d   = stop2_q;
    sample_d  = 1'b0;
    done_d    = 1'b0;
    bit_idx_d = bit_idx_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        bit_idx_d = '0;
        // The accept cycle already counts as timer tick 0, which keeps the
        // registered strobe exactly on cycle (K>>1).
        if (start && !abort) begin
          state_d   = HALF;
          timer_clr = 1'b0;
          timer_en  = 1'b1;
          k_d       = (baud_k < BAUD_W'(MIN_BAUD_K)) ? BAUD_W'(MIN_BAUD_K) : baud_k;
          db_d      = data_bits_e'(data_bits);
          pen_d     = pen;
          stop2_d   = stop2;
        end
      end
      HALF: begin
        timer_en = 1'b1;
        if (half_hit) begin
          sample_d  = 1'b1;
          timer_clr = 1'b1;
          state_d   = BITS;
        end
      end
      BITS: begin
        timer_en = 1'b1;
        if (sample_q) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
        // The done cycle itself stays busy; leave on the following edge.
        if (done_q) begin
          state_d   = IDLE;
          timer_clr = 1'b1;
          bit_idx_d = '0;
        end else if (full_hit) begin
          sample_d  = 1'b1;
          done_d    = (bit_idx_q == last_idx);
          timer_clr = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_clr = 1'b1;
        bit_idx_d = '0;
      end
    endcase

    if (busy && abort) begin
      state_d   = IDLE;
      sample_d  = 1'b0;
      done_d    = 1'b0;
      bit_idx_d = '0;
      timer_clr = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= BAUD_W'(MIN_BAUD_K);
      db_q      <= DB8;
      pen_q     <= 1'b0;
      stop2_q   <= 1'b0;
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      db_q      <= db_d;
      pen_q     <= pen_d;
      stop2_q   <= stop2_d;
      sample_q  <= sample_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign sample  = sample_q;
  assign done    = done_q;
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: per-cycle checks of busy/sample/done/
// bit_idx against hand-derived frame windows.
module tb_uart_rx_sequencer;

  localparam int unsigned BAUD_W = 19;
  localparam int unsigned IDX_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [BAUD_W-1:0] baud_k = '0;
  logic [1:0]        data_bits = 2'b11;
  logic              pen = 1'b0;
  logic              stop2 = 1'b0;
  logic              busy;
  logic              sample;
  logic [IDX_W-1:0]  bit_idx;
  logic              done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  uart_rx_sequencer #(
    .BAUD_W(BAUD_W),
    .IDX_W (IDX_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .baud_k   (baud_k),
    .data_bits(data_bits),
    .pen      (pen),
    .stop2    (stop2),
    .busy     (busy),
    .sample   (sample),
    .bit_idx  (bit_idx),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Frame started at s (accepted at cycle s), truncated after cycle cut.
  function automatic bit in_frame(input int s, input int cut, input int c,
                                  input int k, input int n);
    return (s >= 0) && (c >= s + 1) && (c <= s + k / 2 + (n - 1) * k) && (c <= cut);
  endfunction

  // Cycle c: outputs observed at the negedge before posedge c, then inputs
  // for cycle c are driven.
  task automatic run_case(input int cid, input int len, input int kraw, input int db,
                          input int pn, input int s2, input int st0, input int st1,
                          input int st2, input int st3, input int ab, input int rs,
                          input int chg, input int fa, input int cut, input int fb,
                          input int keff, input int n);
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    baud_k = BAUD_W'(kraw);
    data_bits = 2'(db);
    pen = 1'(pn);
    stop2 = 1'(s2);
    @(negedge clock);
    for (int c = 0; c < len; c++) begin
      bit exp_busy;
      bit exp_s;
      bit exp_d;
      int exp_i;
      @(negedge clock);
      exp_busy = 1'b0;
      exp_s    = 1'b0;
      exp_d    = 1'b0;
      exp_i    = 0;
      for (int fr = 0; fr < 2; fr++) begin
        int s;
        int ct;
        int ph;
        s  = (fr == 0) ? fa : fb;
        ct = (fr == 0) ? cut : 32'h3fff_ffff;
        if (in_frame(s, ct, c, keff, n)) begin
          exp_busy = 1'b1;
          ph = c - s - keff / 2;
          if (ph >= 0 && (ph % keff) == 0) begin
            exp_s = 1'b1;
            exp_i = ph / keff;
            exp_d = (exp_i == n - 1);
          end
        end
      end
      check($sformatf("c%0d busy@%0d", cid, c), 32'(busy), 32'(exp_busy));
      check($sformatf("c%0d sample@%0d", cid, c), 32'(sample), 32'(exp_s));
      check($sformatf("c%0d done@%0d", cid, c), 32'(done), 32'(exp_d));
      if (exp_s || !exp_busy) begin
        check($sformatf("c%0d bit_idx@%0d", cid, c), 32'(bit_idx), 32'(exp_i));
      end
      reset = (c == rs);
      abort = (c == ab);
      start = (c == st0) || (c == st1) || (c == st2) || (c == st3);
      if (chg >= 0 && c >= chg && c < chg + 10) begin
        baud_k = BAUD_W'(4);
        data_bits = 2'b00;
        pen = 1'b1;
        stop2 = 1'b1;
      end else begin
        baud_k = BAUD_W'(kraw);
        data_bits = 2'(db);
        pen = 1'(pn);
        stop2 = 1'(s2);
      end
    end
  endtask

  initial begin
    // 8N1, K=10: N=10, samples 5..95, done at 95
    run_case(1, 100, 10, 3, 0, 0,  0, -1, -1, -1,  -1, -1, -1,  0, 32'h3fff_ffff, -1,  10, 10);
    // 5 data, parity, 2 stops, K=16: N=9, done at 136
    run_case(2, 145, 16, 0, 1, 1,  0, -1, -1, -1,  -1, -1, -1,  0, 32'h3fff_ffff, -1,  16, 9);
    // K=2 clamps to 4, 8N1: samples 2..38
    run_case(3, 45, 2, 3, 0, 0,  0, -1, -1, -1,  -1, -1, -1,  0, 32'h3fff_ffff, -1,  4, 10);
    // abort at 27, restart at 30 -> sample at 35 with bit_idx 0
    run_case(4, 45, 10, 3, 0, 0,  0, 30, -1, -1,  27, -1, -1,  0, 27, 30,  10, 10);
    // starts while busy and on the done cycle ignored, config churn ignored
    run_case(5, 110, 10, 3, 0, 0,  0, 40, 95, 96,  -1, -1, 50,  0, 32'h3fff_ffff, 96,  10, 10);
    // mid-frame reset at 50, later start+abort in idle stays idle
    run_case(6, 90, 10, 3, 0, 0,  0, 70, -1, -1,  70, 50, -1,  0, 50, -1,  10, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
